// File: rtl/mips_harvard_cpu.sv
// Single-cycle MIPS32 subset core with separate instruction and data ports.
// One instruction retires per enabled edge; branches and jumps carry one delay slot.
module mips_harvard_cpu (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00, OP_J     = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
        OP_BNE     = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
        OP_ANDI    = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
        OP_LW      = 6'h23, OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08,
        FN_JALR = 6'h09, FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24,
        FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_SLT = 6'h2A, FN_SLTU = 6'h2B
    } funct_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    logic [31:0] pc;
    logic [31:0] delay_target;
    logic        delay_pending;
    logic        halted;
    logic [31:0] regs [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_val, rt_val, imm_sext, imm_zext;
    logic [31:0] pc_plus4, pc_next, mem_addr;
    logic        wr_en, is_jump, mem_rd, mem_wr, run;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, jump_target;

    assign opcode   = instr_readdata[31:26];
    assign rs       = instr_readdata[25:21];
    assign rt       = instr_readdata[20:16];
    assign rd       = instr_readdata[15:11];
    assign shamt    = instr_readdata[10:6];
    assign funct    = instr_readdata[5:0];
    assign rs_val   = regs[rs];
    assign rt_val   = regs[rt];
    assign imm_sext = {{16{instr_readdata[15]}}, instr_readdata[15:0]};
    assign imm_zext = {16'h0000, instr_readdata[15:0]};
    assign pc_plus4 = pc + 32'd4;
    assign mem_addr = rs_val + imm_sext;

    always_comb begin
        wr_en       = 1'b0;
        wr_addr     = rt;
        wr_data     = '0;
        is_jump     = 1'b0;
        jump_target = pc_plus4;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                wr_addr = rd;
                case (funct)
                    FN_SLL:  begin wr_en = 1'b1; wr_data = rt_val << shamt; end
                    FN_SRL:  begin wr_en = 1'b1; wr_data = rt_val >> shamt; end
                    FN_SRA:  begin wr_en = 1'b1; wr_data = $signed(rt_val) >>> shamt; end
                    FN_JR:   begin is_jump = 1'b1; jump_target = rs_val; end
                    FN_JALR: begin
                        wr_en       = 1'b1;
                        wr_data     = pc + 32'd8;
                        is_jump     = 1'b1;
                        jump_target = rs_val;
                    end
                    FN_ADDU: begin wr_en = 1'b1; wr_data = rs_val + rt_val; end
                    FN_SUBU: begin wr_en = 1'b1; wr_data = rs_val - rt_val; end
                    FN_AND:  begin wr_en = 1'b1; wr_data = rs_val & rt_val; end
                    FN_OR:   begin wr_en = 1'b1; wr_data = rs_val | rt_val; end
                    FN_XOR:  begin wr_en = 1'b1; wr_data = rs_val ^ rt_val; end
                    FN_SLT:  begin wr_en = 1'b1; wr_data = {31'b0, $signed(rs_val) < $signed(rt_val)}; end
                    FN_SLTU: begin wr_en = 1'b1; wr_data = {31'b0, rs_val < rt_val}; end
                    default: ;
                endcase
            end
            OP_J: begin
                is_jump     = 1'b1;
                jump_target = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
            end
            OP_JAL: begin
                is_jump     = 1'b1;
                jump_target = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
                wr_en       = 1'b1;
                wr_addr     = 5'd31;
                wr_data     = pc + 32'd8;
            end
            OP_BEQ: begin
                is_jump     = (rs_val == rt_val);
                jump_target = pc_plus4 + {imm_sext[29:0], 2'b00};
            end
            OP_BNE: begin
                is_jump     = (rs_val != rt_val);
                jump_target = pc_plus4 + {imm_sext[29:0], 2'b00};
            end
            OP_ADDIU: begin wr_en = 1'b1; wr_data = rs_val + imm_sext; end
            OP_SLTI:  begin wr_en = 1'b1; wr_data = {31'b0, $signed(rs_val) < $signed(imm_sext)}; end
            OP_SLTIU: begin wr_en = 1'b1; wr_data = {31'b0, rs_val < imm_sext}; end
            OP_ANDI:  begin wr_en = 1'b1; wr_data = rs_val & imm_zext; end
            OP_ORI:   begin wr_en = 1'b1; wr_data = rs_val | imm_zext; end
            OP_XORI:  begin wr_en = 1'b1; wr_data = rs_val ^ imm_zext; end
            OP_LUI:   begin wr_en = 1'b1; wr_data = {instr_readdata[15:0], 16'h0000}; end
            OP_LW:    begin wr_en = 1'b1; wr_data = data_readdata; mem_rd = 1'b1; end
            OP_SW:    mem_wr = 1'b1;
            default: ;
        endcase
    end

    // The delay-slot instruction always falls through to the saved target,
    // so any control transfer it requests is ignored.
    assign pc_next = delay_pending ? delay_target : pc_plus4;

    assign run            = reset && clk_enable && !halted;
    assign data_read      = run && mem_rd;
    assign data_write     = run && mem_wr;
    assign data_address   = mem_addr;
    assign data_writedata = rt_val;
    assign instr_address  = pc;
    assign register_v0    = regs[2];
    assign active         = !halted;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc            <= RESET_VECTOR;
            delay_target  <= '0;
            delay_pending <= 1'b0;
            halted        <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i[4:0]] <= '0;
            end
        end else if (clk_enable && !halted) begin
            if (wr_en && (wr_addr != 5'd0)) begin
                regs[wr_addr] <= wr_data;
            end
            pc            <= pc_next;
            delay_pending <= is_jump && !delay_pending;
            if (is_jump && !delay_pending) begin
                delay_target <= jump_target;
            end
            halted <= (pc_next == 32'h0000_0000);
        end
    end

endmodule

// File: tb/tb_mips_harvard_cpu.sv
// Directed and random programs run on mips_harvard_cpu, compared each cycle
// against an instruction-level interpreter of the MIPS subset.
module tb_mips_harvard_cpu;

    logic        clk;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    mips_harvard_cpu dut (
        .clk           (clk),
        .reset         (reset),
        .active        (active),
        .register_v0   (register_v0),
        .clk_enable    (clk_enable),
        .instr_address (instr_address),
        .instr_readdata(instr_readdata),
        .data_address  (data_address),
        .data_write    (data_write),
        .data_read     (data_read),
        .data_writedata(data_writedata),
        .data_readdata (data_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int wr_count;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    // Reference interpreter state
    logic [31:0] mregs [32];
    logic [31:0] mmem  [64];
    logic [31:0] mpc, mtgt;
    bit          mpend, mhalt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fetch(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'hBFC0_0000;
        if (off < 32'd256) return imem[off[7:2]];
        return 32'h0;
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        logic [31:0] w;
        w = {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
        return w;
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        logic [31:0] w;
        w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int idx);
        logic [31:0] a;
        a = 32'hBFC0_0000 + 32'(idx * 4);
        return {op[5:0], a[27:2]};
    endfunction

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic m_reset();
        mpc   = 32'hBFC0_0000;
        mtgt  = '0;
        mpend = 0;
        mhalt = 0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
    endtask

    task automatic m_exec(input logic [31:0] ins);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, dst;
        logic [31:0] a, b, res, tgt, addr, seq;
        bit          we, jmp;
        op = ins[31:26]; fn = ins[5:0];
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
        a = mregs[rs]; b = mregs[rt];
        seq = mpc + 32'd4;
        addr = a + sx(ins[15:0]);
        we = 0; jmp = 0; dst = rt; res = '0; tgt = '0;
        case (op)
            6'h00: begin
                dst = rd; we = 1;
                case (fn)
                    6'h00: res = b << sh;
                    6'h02: res = b >> sh;
                    6'h03: res = $signed(b) >>> sh;
                    6'h08: begin we = 0; jmp = 1; tgt = a; end
                    6'h09: begin res = mpc + 32'd8; jmp = 1; tgt = a; end
                    6'h21: res = a + b;
                    6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                    default: we = 0;
                endcase
            end
            6'h02: begin jmp = 1; tgt = {seq[31:28], ins[25:0], 2'b00}; end
            6'h03: begin jmp = 1; tgt = {seq[31:28], ins[25:0], 2'b00}; we = 1; dst = 5'd31; res = mpc + 32'd8; end
            6'h04: begin jmp = (a == b); tgt = seq + (sx(ins[15:0]) << 2); end
            6'h05: begin jmp = (a != b); tgt = seq + (sx(ins[15:0]) << 2); end
            6'h09: begin we = 1; res = a + sx(ins[15:0]); end
            6'h0A: begin we = 1; res = ($signed(a) < $signed(sx(ins[15:0]))) ? 32'd1 : 32'd0; end
            6'h0B: begin we = 1; res = (a < sx(ins[15:0])) ? 32'd1 : 32'd0; end
            6'h0C: begin we = 1; res = a & {16'h0, ins[15:0]}; end
            6'h0D: begin we = 1; res = a | {16'h0, ins[15:0]}; end
            6'h0E: begin we = 1; res = a ^ {16'h0, ins[15:0]}; end
            6'h0F: begin we = 1; res = {ins[15:0], 16'h0}; end
            6'h23: begin we = 1; res = mmem[addr[7:2]]; end
            6'h2B: mmem[addr[7:2]] = b;
            default: ;
        endcase
        if (we && dst != 0) mregs[dst] = res;
        if (mpend) begin
            mpc = mtgt;
            mpend = 0;
        end else begin
            if (jmp) begin mpend = 1; mtgt = tgt; end
            mpc = seq;
        end
        if (mpc == 32'h0) mhalt = 1;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic do_step(input bit en);
        logic [31:0] ins, e_addr, cap_a, cap_d;
        bit          e_rd, e_wr, act, cap_w;
        clk_enable = en;
        #1 instr_readdata = fetch(instr_address);
        #1 data_readdata = dmem[data_address[7:2]];
        #1;
        ins    = fetch(mpc);
        act    = en && !mhalt;
        e_rd   = act && ins[31:26] == 6'h23;
        e_wr   = act && ins[31:26] == 6'h2B;
        e_addr = mregs[ins[25:21]] + sx(ins[15:0]);
        check("pc", instr_address, mpc);
        check("v0", register_v0, mregs[2]);
        check("active", {31'b0, active}, {31'b0, !mhalt});
        check("data_read", {31'b0, data_read}, {31'b0, e_rd});
        check("data_write", {31'b0, data_write}, {31'b0, e_wr});
        if (e_rd || e_wr) check("data_address", data_address, e_addr);
        if (e_wr) check("data_writedata", data_writedata, mregs[ins[20:16]]);
        cap_w = data_write; cap_a = data_address; cap_d = data_writedata;
        @(posedge clk);
        if (cap_w) begin
            dmem[cap_a[7:2]] = cap_d;
            wr_count++;
        end
        if (act) m_exec(ins);
        @(negedge clk);
    endtask

    // Called at a falling edge; reset is asserted between edges and held over one edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_pc", instr_address, 32'hBFC0_0000);
        check("rst_v0", register_v0, 32'h0);
        check("rst_active", {31'b0, active}, 32'd1);
        check("rst_dwrite", {31'b0, data_write}, 32'd0);
        check("rst_dread", {31'b0, data_read}, 32'd0);
        @(posedge clk);
        #1 check("rst_hold_pc", instr_address, 32'hBFC0_0000);
        @(negedge clk);
        reset = 1'b1;
        m_reset();
    endtask

    task automatic run_to_halt(input int budget, input bit rnd_en);
        int n;
        n = 0;
        while (!mhalt && n < budget) begin
            do_step(rnd_en ? ($urandom_range(0, 7) != 0) : 1'b1);
            n++;
        end
        total++;
        if (!mhalt) begin
            bad++;
            $error("FAIL halt_timeout observed=running expected=halted");
        end
        for (int k = 0; k < 3; k++) do_step(1'b1);
    endtask

    task automatic load_clear();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    function automatic logic [31:0] gen_instr(input int i, input int n);
        logic [5:0] fns [10] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        logic [5:0] ops [7]  = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        int kind, rs, rt, rd, t;
        kind = $urandom_range(0, 19);
        rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
        t  = $urandom_range(i + 1, n);
        if (kind <= 5)  return enc_r(rs, rt, rd, $urandom_range(0, 31), int'(fns[$urandom_range(0, 9)]));
        if (kind <= 11) return enc_i(int'(ops[$urandom_range(0, 6)]), rs, rt, $urandom_range(0, 65535));
        if (kind <= 13) return enc_i(6'h23, rs, rt, $urandom_range(0, 65535));
        if (kind <= 15) return enc_i(6'h2B, rs, rt, $urandom_range(0, 65535));
        if (kind == 17) return enc_j($urandom_range(2, 3), t);
        if (kind == 18) return ($urandom_range(0, 1) == 1) ? enc_i(6'h3F, rs, rt, $urandom_range(0, 65535))
                                                           : enc_r(rs, rt, rd, 0, 6'h3F);
        return enc_i($urandom_range(4, 5), rs, rt, t - (i + 1));
    endfunction

    initial begin
        reset = 1'b1;
        clk_enable = 1'b1;
        instr_readdata = '0;
        data_readdata = '0;
        wr_count = 0;
        for (int i = 0; i < 64; i++) begin
            dmem[i] = '0;
            mmem[i] = '0;
        end
        m_reset();
        load_clear();
        @(negedge clk);

        // Halt through JR $0 with delay slot; $0 writes discarded
        imem[0] = enc_i(6'h09, 0, 0, 1);
        imem[1] = enc_i(6'h09, 0, 2, 1);
        imem[2] = enc_r(0, 0, 0, 0, 6'h08);
        imem[3] = enc_i(6'h09, 0, 0, 0);
        do_reset();
        for (int k = 0; k < 4; k++) do_step(1'b1);
        check("t1_pc", instr_address, 32'h0);
        check("t1_active", {31'b0, active}, 32'd0);
        check("t1_v0", register_v0, 32'h1);
        for (int k = 0; k < 3; k++) do_step(1'b1);
        check("t1_v0_frozen", register_v0, 32'h1);

        // Store then load
        load_clear();
        imem[0] = enc_i(6'h09, 0, 3, 16'h1234);
        imem[1] = enc_i(6'h2B, 0, 3, 8);
        imem[2] = enc_i(6'h23, 0, 2, 8);
        imem[3] = enc_r(0, 0, 0, 0, 6'h08);
        do_reset();
        wr_count = 0;
        run_to_halt(20, 1'b0);
        check("t2_v0", register_v0, 32'h0000_1234);
        check("t2_mem", dmem[2], 32'h0000_1234);
        check("t2_wr_cycles", 32'(wr_count), 32'd1);

        // Taken BEQ with delay slot, stall, untaken BNE
        load_clear();
        imem[0] = enc_i(6'h04, 0, 0, 2);
        imem[1] = enc_i(6'h09, 2, 2, 5);
        imem[2] = enc_i(6'h09, 2, 2, 100);
        imem[3] = enc_i(6'h05, 0, 0, 5);
        imem[4] = enc_i(6'h09, 2, 2, 2);
        imem[5] = enc_r(0, 0, 0, 0, 6'h08);
        do_reset();
        do_step(1'b1);
        do_step(1'b1);
        check("t3_v0_slot", register_v0, 32'h5);
        for (int k = 0; k < 3; k++) do_step(1'b0);
        check("t3_stall_pc", instr_address, 32'hBFC0_000C);
        check("t3_stall_v0", register_v0, 32'h5);
        run_to_halt(20, 1'b0);
        check("t3_v0", register_v0, 32'h7);

        // JAL / JR $31 return to JAL+8
        load_clear();
        imem[0] = enc_j(6'h03, 5);
        imem[2] = enc_r(31, 0, 2, 0, 6'h21);
        imem[3] = enc_r(0, 0, 0, 0, 6'h08);
        imem[5] = enc_r(31, 0, 0, 0, 6'h08);
        do_reset();
        run_to_halt(20, 1'b0);
        check("t4_v0", register_v0, 32'hBFC0_0008);

        // JALR links into rd and jumps through rs
        load_clear();
        imem[0] = enc_i(6'h0F, 0, 5, 16'hBFC0);
        imem[1] = enc_i(6'h0D, 5, 5, 16'h0014);
        imem[2] = enc_r(5, 0, 2, 0, 6'h09);
        imem[4] = enc_i(6'h09, 0, 2, 99);
        imem[5] = enc_r(0, 0, 0, 0, 6'h08);
        do_reset();
        run_to_halt(20, 1'b0);
        check("t5_v0", register_v0, 32'hBFC0_0010);

        // Reset while a jump is pending aborts it
        load_clear();
        imem[0] = enc_i(6'h09, 0, 2, 9);
        imem[1] = enc_j(6'h02, 5);
        imem[5] = enc_r(0, 0, 0, 0, 6'h08);
        do_reset();
        do_step(1'b1);
        do_step(1'b1);
        check("t6_v0_before", register_v0, 32'h9);
        do_reset();
        do_step(1'b1);
        do_step(1'b1);
        check("t6_pc_restart", instr_address, 32'hBFC0_0008);
        run_to_halt(40, 1'b0);

        // Random programs with random clock enables
        for (int p = 0; p < 8; p++) begin
            load_clear();
            for (int i = 0; i < 40; i++) imem[i] = gen_instr(i, 40);
            imem[40] = enc_r(0, 0, 0, 0, 6'h08);
            for (int i = 0; i < 64; i++) begin
                dmem[i] = $urandom;
                mmem[i] = dmem[i];
            end
            do_reset();
            if (p == 0) begin
                for (int k = 0; k < 12; k++) do_step(1'b1);
                do_reset();
            end
            run_to_halt(600, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
